// File: rtl/logu_pkg.sv
// rtl/logu_pkg.sv - opcode/state types and helpers shared by the logic unit
package logu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_PASS = 3'b111
  } opsel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(opsel_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/logu_step.sv
// rtl/logu_step.sv - one-bit shift/rotate step (combinational)
module logu_step
  import logu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  opsel_t           op,
  output logic [WIDTH-1:0] next,
  output logic             shift_out
);

  always_comb begin
    next      = data;
    shift_out = 1'b0;
    case (op)
      OP_SHL: begin
        next      = {data[WIDTH-2:0], 1'b0};
        shift_out = data[WIDTH-1];
      end
      OP_SHR: begin
        next      = {1'b0, data[WIDTH-1:1]};
        shift_out = data[0];
      end
      OP_ROL: begin
        next      = {data[WIDTH-2:0], data[WIDTH-1]};
        shift_out = data[WIDTH-1];
      end
      default: begin
        next      = data;
        shift_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - sequential N-bit logic/shift unit; LOGU_ZERO_FLAG_EN adds the zero output
module logic_unit_seq
  import logu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opsel,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef LOGU_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             cout
);

  state_t           state;
  opsel_t           op;
  opsel_t           op_in;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] logic_res;
  logic             step_bit;
  logic [SHW-1:0]   count;
  logic [SHW-1:0]   shamt_eff;

  assign op_in     = opsel_t'(opsel);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Only reachable for non-power-of-2 WIDTH, where shamt can exceed WIDTH-1.
  assign shamt_eff = ({1'b0, shamt} >= (SHW+1)'(WIDTH)) ? SHW'(WIDTH - 1) : shamt;

  always_comb begin
    logic_res = a;
    case (op_in)
      OP_AND:  logic_res = a & b;
      OP_OR:   logic_res = a | b;
      OP_XOR:  logic_res = a ^ b;
      OP_NOT:  logic_res = ~a;
      default: logic_res = a;
    endcase
  end

  logu_step #(.WIDTH(WIDTH)) u_step (
    .data      (work),
    .op        (op),
    .next      (step_next),
    .shift_out (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= OP_PASS;
      work  <= '0;
      count <= '0;
      out   <= '0;
      cout  <= 1'b0;
`ifdef LOGU_ZERO_FLAG_EN
      zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op <= op_in;
            if (is_shift(op_in) && (shamt_eff != '0)) begin
              work  <= a;
              count <= shamt_eff;
              state <= SHIFT;
            end else begin
              out   <= logic_res;
              cout  <= 1'b0;
`ifdef LOGU_ZERO_FLAG_EN
              zero  <= (logic_res == '0);
`endif
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          work  <= step_next;
          cout  <= step_bit;
          count <= count - SHW'(1);
          if (count == SHW'(1)) begin
            out   <= step_next;
`ifdef LOGU_ZERO_FLAG_EN
            zero  <= (step_next == '0);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - directed-vector bench for logic_unit_seq
module tb_logic_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opsel;
  logic [2:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       cout;
`ifdef LOGU_ZERO_FLAG_EN
  logic       zero;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opsel     (opsel),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
`ifdef LOGU_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one op, waits for out_valid, checks result and latency, then drains it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input logic [2:0] sh, input logic [7:0] exp_out,
                        input logic exp_cout, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    opsel = op; a = va; b = vb; shamt = sh; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = ~va; b = ~vb;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat <= 20) begin
      lat++;
      @(negedge clk);
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".out"}, {24'd0, out}, {24'd0, exp_out});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
`ifdef LOGU_ZERO_FLAG_EN
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp_out == 8'h00)});
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".drained"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opsel = '0; shamt = '0;
    #12;
    check("rst.out", {24'd0, out}, 32'd0);
    check("rst.flags", {29'd0, cout, out_valid, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;

    run_op("xor",   3'b010, 8'hC3, 8'h5A, 3'd0, 8'h99, 1'b0, 1);
    run_op("and",   3'b000, 8'hF0, 8'h0F, 3'd0, 8'h00, 1'b0, 1);
    run_op("or",    3'b001, 8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 1);
    run_op("not",   3'b011, 8'h3C, 8'h00, 3'd5, 8'hC3, 1'b0, 1);
    run_op("pass",  3'b111, 8'hA5, 8'h11, 3'd2, 8'hA5, 1'b0, 1);
    run_op("shl3",  3'b100, 8'h81, 8'h00, 3'd3, 8'h08, 1'b0, 4);
    run_op("shl1",  3'b100, 8'h81, 8'h00, 3'd1, 8'h02, 1'b1, 2);
    run_op("rol1",  3'b110, 8'h81, 8'h00, 3'd1, 8'h03, 1'b1, 2);
    run_op("shr0",  3'b101, 8'h81, 8'h00, 3'd0, 8'h81, 1'b0, 1);
    run_op("shr3",  3'b101, 8'h81, 8'h00, 3'd3, 8'h10, 1'b0, 4);
    run_op("rol7",  3'b110, 8'h81, 8'h00, 3'd7, 8'hC0, 1'b0, 8);
    run_op("shl7",  3'b100, 8'hFF, 8'h00, 3'd7, 8'h80, 1'b1, 8);
    run_op("shr7",  3'b101, 8'hFF, 8'h00, 3'd7, 8'h01, 1'b1, 8);

    // Backpressure: result must hold while a competing request is presented.
    @(negedge clk);
    opsel = 3'b100; a = 8'h81; shamt = 3'd1; in_valid = 1'b1;
    @(posedge clk);
    #1 opsel = 3'b111; a = 8'h5A; shamt = 3'd0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp.hold", {21'd0, out_valid, in_ready, cout, out}, {21'd0, 1'b1, 1'b0, 1'b1, 8'h02});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp.idle", {22'd0, out_valid, in_ready, out}, {22'd0, 1'b0, 1'b1, 8'h02});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp.next", {23'd0, out_valid, out}, {23'd0, 1'b1, 8'h5A});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Asynchronous reset in the middle of a 7-step shift.
    @(negedge clk);
    opsel = 3'b100; a = 8'hFF; shamt = 3'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst.out", {24'd0, out}, 32'd0);
    check("arst.flags", {29'd0, cout, out_valid, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("arst.noresult", seen, 0);

    run_op("post",  3'b010, 8'hFF, 8'h0F, 3'd0, 8'hF0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
